// File: rtl/rom_fetch_unit_if.sv
// Bus between the ROM prefetch unit, the program ROM and the decoder.
// The master side is the fetch unit; the slave side is the ROM/decoder environment.
interface rom_fetch_unit_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [7:0]    rom_address;
  logic [7:0]    rom_data;
  logic [7:0]    instr;
  logic [7:0]    instr_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic          jump;
  logic [7:0]    jump_addr;
  logic [LW-1:0] level;

  modport master (
    output rom_address, instr, instr_pc, instr_valid, level,
    input  rom_data, instr_ready, jump, jump_addr
  );

  modport slave (
    input  rom_address, instr, instr_pc, instr_valid, level,
    output rom_data, instr_ready, jump, jump_addr
  );
endinterface

// File: rtl/rom_fetch_unit.sv
// Instruction prefetch: drives the ROM address, captures its registered data one
// cycle later and buffers {byte, pc} pairs in a small FIFO for the decoder.
module rom_fetch_unit #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [7:0]  RESET_ADDR = 8'h00
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  rom_fetch_unit_if.master bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [7:0]    fetch_pc_q, fetch_pc_d;
  logic          pending_q, pending_d;
  logic [7:0]    pending_pc_q, pending_pc_d;
  logic [LW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    data_q [DEPTH];
  logic [7:0]    pc_q   [DEPTH];

  logic          push_c, pop_c, issue_c;
  logic [LW:0]   occ_c;

  // Occupancy counts the in-flight byte so a push can never find the FIFO full.
  assign occ_c   = {1'b0, count_q} + (LW+1)'(pending_q);
  assign issue_c = !bus.jump && (occ_c < (LW+1)'(DEPTH));
  assign push_c  = !bus.jump && pending_q;
  assign pop_c   = !bus.jump && (count_q != '0) && bus.instr_ready;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    pending_d    = pending_q;
    pending_pc_d = pending_pc_q;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;

    if (bus.jump) begin
      fetch_pc_d = bus.jump_addr;
      pending_d  = 1'b0;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      pending_d = issue_c;
      if (issue_c) begin
        pending_pc_d = fetch_pc_q;
        fetch_pc_d   = fetch_pc_q + 8'd1;
      end
      if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + LW'(push_c) - LW'(pop_c);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fetch_pc_q   <= RESET_ADDR;
      pending_q    <= 1'b0;
      pending_pc_q <= 8'h00;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pending_q    <= pending_d;
      pending_pc_q <= pending_pc_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // Storage is cleared on reset so the head reads 8'h00 until the first push.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= 8'h00;
        pc_q[i]   <= 8'h00;
      end
    end else if (push_c) begin
      data_q[wr_ptr_q] <= bus.rom_data;
      pc_q[wr_ptr_q]   <= pending_pc_q;
    end
  end

  assign bus.rom_address = fetch_pc_q;
  assign bus.instr       = data_q[rd_ptr_q];
  assign bus.instr_pc    = pc_q[rd_ptr_q];
  assign bus.instr_valid = (count_q != '0);
  assign bus.level       = count_q;

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Directed bench for rom_fetch_unit against a registered ROM model (DATA = ADDR ^ A5).
module tb_rom_fetch_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  rom_fetch_unit_if #(.DEPTH(4)) bus ();

  rom_fetch_unit #(.DEPTH(4), .RESET_ADDR(8'h00)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.rom_data <= bus.rom_address ^ 8'hA5;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.jump = 1'b0;
    bus.jump_addr = 8'h00;
    bus.instr_ready = 1'b0;
    step();
    step();
  endtask

  // Consumes n instructions with ready held high; expects consecutive PCs from first_pc.
  task automatic collect(input int n, input logic [7:0] first_pc, input string name);
    int got = 0;
    logic [7:0] exp_pc = first_pc;
    bus.instr_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < n; cyc++) begin
      if (bus.instr_valid) begin
        vectors++;
        if ({bus.instr_pc, bus.instr} !== {exp_pc, exp_pc ^ 8'hA5}) begin
          miscompares++;
          $display("FAIL %s[%0d]: pc/instr got %h/%h want %h/%h", name, got,
                   bus.instr_pc, bus.instr, exp_pc, exp_pc ^ 8'hA5);
        end
        got++;
        exp_pc = exp_pc + 8'd1;
      end
      if (got < n) step();
    end
    if (got < n) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got %0d instrs want %0d", name, got, n);
    end
  endtask

  // Releases reset with ready high and checks the start-up stream.
  task automatic check_restart(input string name);
    rst_n = 1'b1;
    bus.instr_ready = 1'b1;
    step();
    vectors++;
    if (bus.instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_edge0_valid: got %b want 0", name, bus.instr_valid);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      vectors++;
      if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 8'(i), 8'(i) ^ 8'hA5}) begin
        miscompares++;
        $display("FAIL %s_stream[%0d]: v/pc/instr got %b/%h/%h want 1/%h/%h", name, i,
                 bus.instr_valid, bus.instr_pc, bus.instr, 8'(i), 8'(i) ^ 8'hA5);
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if ({bus.rom_address, bus.instr, bus.instr_pc, bus.instr_valid, bus.level} !==
        {8'h00, 8'h00, 8'h00, 1'b0, 3'd0}) begin
      miscompares++;
      $display("FAIL reset_state: addr/instr/pc/v/lvl got %h/%h/%h/%b/%0d want 00/00/00/0/0",
               bus.rom_address, bus.instr, bus.instr_pc, bus.instr_valid, bus.level);
    end
  endtask

  task automatic test_stream();
    apply_reset();
    check_restart("stream");
  endtask

  task automatic test_backpressure();
    apply_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i >= 5) begin
        vectors++;
        if ({bus.level, bus.rom_address} !== {3'd4, 8'h04}) begin
          miscompares++;
          $display("FAIL bp_full[%0d]: lvl/addr got %0d/%h want 4/04", i, bus.level, bus.rom_address);
        end
      end
    end
    collect(5, 8'h00, "bp_drain");
  endtask

  task automatic test_jump();
    int waited = 0;
    apply_reset();
    rst_n = 1'b1;
    step();
    while (bus.level != 3'd3 && waited < 10) begin
      step();
      waited++;
    end
    vectors++;
    if (bus.level !== 3'd3) begin
      miscompares++;
      $display("FAIL jump_prefill: level got %0d want 3", bus.level);
    end
    bus.jump = 1'b1;
    bus.jump_addr = 8'h40;
    bus.instr_ready = 1'b1;
    step();
    bus.jump = 1'b0;
    bus.jump_addr = 8'h00;
    vectors++;
    if ({bus.instr_valid, bus.level, bus.rom_address} !== {1'b0, 3'd0, 8'h40}) begin
      miscompares++;
      $display("FAIL jump_flush: v/lvl/addr got %b/%0d/%h want 0/0/40",
               bus.instr_valid, bus.level, bus.rom_address);
    end
    step();
    vectors++;
    if ({bus.instr_valid, bus.rom_address} !== {1'b0, 8'h41}) begin
      miscompares++;
      $display("FAIL jump_issue: v/addr got %b/%h want 0/41", bus.instr_valid, bus.rom_address);
    end
    step();
    vectors++;
    if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 8'h40, 8'hE5}) begin
      miscompares++;
      $display("FAIL jump_first: v/pc/instr got %b/%h/%h want 1/40/e5",
               bus.instr_valid, bus.instr_pc, bus.instr);
    end
    collect(3, 8'h40, "jump_stream");
  endtask

  task automatic test_wrap();
    apply_reset();
    rst_n = 1'b1;
    bus.instr_ready = 1'b1;
    bus.jump = 1'b1;
    bus.jump_addr = 8'hFE;
    step();
    bus.jump = 1'b0;
    collect(4, 8'hFE, "wrap");
  endtask

  task automatic test_random();
    logic [7:0] exp_pc = 8'h00;
    int accepted = 0;
    apply_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      bus.instr_ready = 1'($urandom_range(0, 1));
      if (bus.instr_valid && bus.instr_ready) begin
        vectors++;
        if ({bus.instr_pc, bus.instr} !== {exp_pc, exp_pc ^ 8'hA5}) begin
          miscompares++;
          $display("FAIL rand[%0d]: pc/instr got %h/%h want %h/%h", i,
                   bus.instr_pc, bus.instr, exp_pc, exp_pc ^ 8'hA5);
        end
        exp_pc = exp_pc + 8'd1;
        accepted++;
      end
      if (bus.level > 3'd4) begin
        vectors++;
        miscompares++;
        $display("FAIL rand_level[%0d]: level got %0d want <=4", i, bus.level);
      end
    end
    vectors++;
    if (accepted < 50) begin
      miscompares++;
      $display("FAIL rand_throughput: accepted got %0d want >=50", accepted);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    rst_n = 1'b1;
    step();
    step();
    step();
    vectors++;
    if ({bus.level, bus.rom_address} !== {3'd2, 8'h03}) begin
      miscompares++;
      $display("FAIL mid_prefill: lvl/addr got %0d/%h want 2/03", bus.level, bus.rom_address);
    end
    rst_n = 1'b0;
    bus.instr_ready = 1'b1;
    step();
    vectors++;
    if ({bus.instr_valid, bus.level, bus.rom_address} !== {1'b0, 3'd0, 8'h00}) begin
      miscompares++;
      $display("FAIL mid_reset: v/lvl/addr got %b/%0d/%h want 0/0/00",
               bus.instr_valid, bus.level, bus.rom_address);
    end
    check_restart("mid_restart");
  endtask

  initial begin
    rst_n = 1'b0;
    bus.jump = 1'b0;
    bus.jump_addr = 8'h00;
    bus.instr_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_jump();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rom_fetch_unit.md
# rom_fetch_unit

Instruction fetch and prefetch stage between the program ROM and the processor decode logic. It drives the ROM address bus and captures the ROM's registered data output one cycle later. Fetched bytes are buffered, each tagged with its address, in a small FIFO and handed to the decoder over a valid/ready handshake. A jump input flushes the buffer and redirects fetching.

## Interface
- DEPTH, 4: FIFO entries, power of two, 2..16
- RESET_ADDR, 8'h00: first fetch address after reset
- CLK  input  1  system clock; all state updates on the rising edge
- RESET  input  1  synchronous, active-low reset
- ROM_ADDRESS  output  8  address to ROM ADDR; registered fetch PC
- ROM_DATA  input  8  ROM DATA; valid the cycle after the ROM samples ROM_ADDRESS
- INSTR  output  8  FIFO head instruction byte
- INSTR_PC  output  8  address INSTR was fetched from
- INSTR_VALID  output  1  FIFO non-empty
- INSTR_READY  input  1  decoder accepts head this cycle
- JUMP  input  1  single-cycle redirect request
- JUMP_ADDR  input  8  redirect target, sampled when JUMP=1
- LEVEL  output  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- State:
  - fetch_pc (8b)
  - pending flag plus pending_pc (one request in flight)
  - FIFO of {byte, pc}
  - count
- ROM_ADDRESS = fetch_pc at all times.
- Issue condition: count + pending < DEPTH. Pops in the same cycle are ignored, so the FIFO can never overflow.
- On an issuing edge:
  - pending <= 1, pending_pc <= fetch_pc
  - fetch_pc <= fetch_pc + 1, modulo 256 (8'hFF wraps to 8'h00)
- On a non-issuing edge: pending <= 0.
- Push: on every edge where pending=1 (and no JUMP), write {ROM_DATA, pending_pc} at the tail.
- Pop: on every edge where INSTR_VALID & INSTR_READY (and no JUMP).
- Simultaneous push and pop: count unchanged.
- JUMP=1 at an edge:
  - count <= 0; pointers reset; pending <= 0, so the in-flight byte is discarded
  - fetch_pc <= JUMP_ADDR; no issue on that edge
  - Any pop or handshake in the JUMP cycle has no state effect; JUMP wins.
- Priority order: RESET > JUMP > normal push/pop/issue.
- INSTR/INSTR_PC are don't-care while INSTR_VALID=0, except immediately after reset, when they are 8'h00.

## Timing
- Reset values:
  - ROM_ADDRESS = RESET_ADDR
  - INSTR = 0, INSTR_PC = 0
  - INSTR_VALID = 0, LEVEL = 0, pending = 0
- Reset asserted mid-operation discards the FIFO and any in-flight byte on that edge.
- ROM latency is 1 cycle: the address sampled at edge n gives data captured at edge n+1.
- First instruction after reset release (edge 0 = first edge with RESET=1):
  - edge 0: fetch RESET_ADDR
  - edge 1: push
  - INSTR_VALID high in the cycle after edge 1
- Jump latency (JUMP high in cycle c):
  - edge c: flush
  - edge c+1: issue JUMP_ADDR
  - edge c+2: push
  - INSTR_VALID=0 in cycles c+1 and c+2, high from cycle c+3 with INSTR_PC = JUMP_ADDR
- Sustained throughput with INSTR_READY held high: 1 instruction per cycle. INSTR_PC increments by 1 per cycle with no bubbles.
- With INSTR_READY low:
  - Fetch stops once count + pending = DEPTH.
  - LEVEL settles at DEPTH.
  - ROM_ADDRESS holds the next unfetched address.
- Full FIFO with a pop: issue resumes the following edge. No byte is lost or duplicated.
- Outputs are driven directly from registers or the FIFO head; there is no combinational path from INSTR_READY or JUMP to any output.

## Test plan
- ROM model DATA = ADDR ^ 8'hA5, registered. Reset, then hold INSTR_READY=1:
  - INSTR_VALID first high in cycle 2
  - stream (INSTR_PC, INSTR) = (00, A5), (01, A4), (02, A7)…, one per cycle
- Hold INSTR_READY=0 for 10 cycles after reset:
  - LEVEL reaches 4 and stays; ROM_ADDRESS stays 8'h04
  - On release, PCs 00..04 are delivered in order with no gaps or duplicates.
- JUMP with JUMP_ADDR=8'h40 while the FIFO holds 3 entries:
  - INSTR_VALID low for 2 cycles
  - next INSTR_PC = 40, INSTR = E5
  - no pre-jump PC is ever delivered afterwards
- Start with JUMP_ADDR=8'hFE and INSTR_READY=1: PCs delivered are FE, FF, 00, 01 (wrap-around).
- Toggle INSTR_READY pseudo-randomly for 200 cycles against a scoreboard: every accepted INSTR_PC is previous+1 mod 256 and INSTR matches the ROM model.
- Assert RESET low mid-stream with 2 entries plus one pending:
  - the next cycle shows INSTR_VALID=0, LEVEL=0, ROM_ADDRESS=RESET_ADDR
  - the restart sequence matches scenario 1
